// File: rtl/jtopl_wrseq.sv
// Host-side write sequencer for jtopl: queues (reg, val) commands and replays each one
// as an address stroke then a data stroke, with settling waits, while polling status when idle.
module jtopl_wrseq #(
    parameter int FIFO_AW   = 2,
    parameter int STB_TICKS = 2,
    parameter int ADDR_WAIT = 12,
    parameter int DATA_WAIT = 84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_val,
    output logic [7:0] opl_din,
    output logic       opl_addr,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    input  logic [7:0] opl_dout,
    output logic [7:0] status,
    output logic       busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [7:0] STB_LD  = 8'(STB_TICKS - 1);
    localparam logic [7:0] AWT_LD  = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DWT_LD  = 8'(DATA_WAIT - 1);

    typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;

    state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] din_nxt;
    logic       addr_nxt, cs_n_nxt, wr_n_nxt;
    logic [7:0] val_q;

    logic [7:0]         fifo_reg [DEPTH];
    logic [7:0]         fifo_val [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push, pop, not_empty;

    assign not_empty = (count != '0);
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = cen && (state == IDLE) && not_empty;
    assign busy      = (state != IDLE) || not_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_reg[wr_ptr] <= cmd_reg;
                fifo_val[wr_ptr] <= cmd_val;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State and all bus outputs are registered; nothing moves without cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opl_din  <= '0;
            opl_addr <= 1'b0;
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b1;
            status   <= '0;
            val_q    <= '0;
        end else if (cen) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            opl_din  <= din_nxt;
            opl_addr <= addr_nxt;
            opl_cs_n <= cs_n_nxt;
            opl_wr_n <= wr_n_nxt;
            if (state == IDLE)
                status <= opl_dout;
            if (pop)
                val_q <= fifo_val[rd_ptr];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (not_empty)  state_nxt = ASTB;
            ASTB:    if (cnt == '0)  state_nxt = AWAIT;
            AWAIT:   if (cnt == '0)  state_nxt = DSTB;
            DSTB:    if (cnt == '0)  state_nxt = DWAIT;
            DWAIT:   if (cnt == '0)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus pins and the tick counter.
    always_comb begin
        din_nxt  = opl_din;
        addr_nxt = opl_addr;
        cs_n_nxt = opl_cs_n;
        wr_n_nxt = opl_wr_n;
        cnt_nxt  = (cnt == '0) ? cnt : cnt - 8'd1;
        case (state)
            IDLE: begin
                addr_nxt = 1'b0;
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b1;
                if (not_empty) begin
                    din_nxt  = fifo_reg[rd_ptr];
                    wr_n_nxt = 1'b0;
                    cnt_nxt  = STB_LD;
                end
            end
            ASTB: if (cnt == '0) begin
                cs_n_nxt = 1'b1;
                wr_n_nxt = 1'b1;
                cnt_nxt  = AWT_LD;
            end
            AWAIT: if (cnt == '0) begin
                din_nxt  = val_q;
                addr_nxt = 1'b1;
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b0;
                cnt_nxt  = STB_LD;
            end
            DSTB: if (cnt == '0) begin
                cs_n_nxt = 1'b1;
                wr_n_nxt = 1'b1;
                cnt_nxt  = DWT_LD;
            end
            DWAIT: if (cnt == '0) begin
                addr_nxt = 1'b0;
                cs_n_nxt = 1'b0;
                wr_n_nxt = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jtopl_wrseq.sv
// Bench for jtopl_wrseq: a bus monitor classifies each clk sample as idle/strobe/released,
// checks run lengths against the configured tick counts and strobe data against a queue.
module tb_jtopl_wrseq;
    localparam int STB = 2;
    localparam int AW  = 12;
    localparam int DW  = 84;
    localparam int CMD_TICKS = 2*STB + AW + DW;

    logic       clk = 1'b0;
    logic       rst, cen, cmd_valid, cmd_ready;
    logic [7:0] cmd_reg, cmd_val, opl_din, opl_dout, status;
    logic       opl_addr, opl_cs_n, opl_wr_n, busy;

    always #5 clk = ~clk;

    jtopl_wrseq #(.FIFO_AW(2), .STB_TICKS(STB), .ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
        .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
        .opl_dout(opl_dout), .status(status), .busy(busy)
    );

    typedef struct { logic [7:0] rg; logic [7:0] vl; } cmd_t;
    typedef struct { logic [7:0] dout; logic [7:0] exp_status; } svec_t;

    cmd_t  sb[$];
    svec_t svec[4];
    cmd_t  cvec[6];

    int checks = 0, errors = 0, cyc = 0, cen_div = 1;
    int prev_cls = 0, run_len = 0, last_addr = 1, strokes_done = 0;
    logic [7:0]  exp_val = 8'h00;
    logic [19:0] prev_bus = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic end_run(input int cls, input int len);
        if (cls == 1)
            chk("strobe_width", len, STB*cen_div);
        else if (cls == 2)
            chk(last_addr ? "data_wait" : "addr_wait", len, (last_addr ? DW : AW)*cen_div);
    endtask

    task automatic start_run(input int cls);
        cmd_t e;
        if (cls != 1) return;
        if (!opl_addr) begin
            chk("addr_after_data", last_addr, 1);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_stroke: din 0x%0h with nothing queued (cycle %0d)", opl_din, cyc);
            end else begin
                e = sb.pop_front();
                chk("addr_din", int'(opl_din), int'(e.rg));
                exp_val = e.vl;
            end
            last_addr = 0;
        end else begin
            chk("data_after_addr", last_addr, 0);
            chk("data_din", int'(opl_din), int'(exp_val));
            last_addr = 1;
            strokes_done++;
        end
    endtask

    // One clk cycle: sample on the falling edge, run the monitor, then set cen for the next edge.
    task automatic tick();
        logic r_edge, c_edge;
        int cls;
        logic [19:0] bus;
        r_edge = rst;
        c_edge = cen;
        @(negedge clk);
        cyc++;
        cls = opl_cs_n ? 2 : (opl_wr_n ? 0 : 1);
        bus = {opl_din, opl_addr, opl_cs_n, opl_wr_n, status, 1'b0};
        if (r_edge) begin
            sb.delete();
            prev_cls  = cls;
            run_len   = 1;
            last_addr = 1;
        end else begin
            if (!c_edge) chk("steady_on_cen0", int'(bus), int'(prev_bus));
            if (cls == prev_cls) run_len++;
            else begin
                end_run(prev_cls, run_len);
                start_run(cls);
                prev_cls = cls;
                run_len  = 1;
            end
        end
        prev_bus = bus;
        cen = ((cyc % cen_div) == 0);
    endtask

    task automatic push(input cmd_t c, input int budget, output int waited);
        cmd_reg = c.rg; cmd_val = c.vl; cmd_valid = 1'b1; waited = 0;
        while (!cmd_ready && waited < budget) begin tick(); waited++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: ready stayed low for %0d cycles", waited);
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin tick(); n++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy after %0d cycles", n);
        end
    endtask

    task automatic chk_idle_levels(input string nm);
        chk({nm, "_din"},   int'(opl_din), 0);
        chk({nm, "_addr"},  int'(opl_addr), 0);
        chk({nm, "_cs_n"},  int'(opl_cs_n), 0);
        chk({nm, "_wr_n"},  int'(opl_wr_n), 1);
        chk({nm, "_status"}, int'(status), 0);
        chk({nm, "_busy"},  int'(busy), 0);
        chk({nm, "_ready"}, int'(cmd_ready), 1);
    endtask

    initial begin
        int w, n, total, base;
        svec[0] = '{8'hE6, 8'hE6};
        svec[1] = '{8'h00, 8'h00};
        svec[2] = '{8'h5A, 8'h5A};
        svec[3] = '{8'hFF, 8'hFF};
        cvec[0] = '{8'h20, 8'h21};
        cvec[1] = '{8'hA0, 8'h44};
        cvec[2] = '{8'hB0, 8'h32};
        cvec[3] = '{8'h40, 8'h3F};
        cvec[4] = '{8'hBD, 8'h20};
        cvec[5] = '{8'h01, 8'hC5};

        rst = 1'b1; cen = 1'b1; cmd_valid = 1'b0; cmd_reg = '0; cmd_val = '0; opl_dout = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        chk_idle_levels("reset");

        // Status polling in idle
        for (int i = 0; i < 4; i++) begin
            opl_dout = svec[i].dout;
            tick();
            chk("status_poll", int'(status), int'(svec[i].exp_status));
        end

        // Single command, status frozen while it runs
        push(cvec[0], 10, w);
        chk("busy_after_push", int'(busy), 1);
        tick();
        opl_dout = 8'h33;
        wait_idle(300, n);
        chk("single_cmd_ticks", n, CMD_TICKS);
        chk("status_frozen", int'(status), 8'hFF);
        chk("single_strokes", strokes_done, 1);
        tick();
        chk("status_resume", int'(status), 8'h33);

        // Five back-to-back, then a sixth held against a full FIFO
        base = strokes_done; total = 0;
        for (int i = 1; i < 6; i++) begin
            push(cvec[i], 10, w);
            total += w;
        end
        chk("b2b_stalls", total, 0);
        chk("ready_when_full", int'(cmd_ready), 0);
        push(cvec[0], 400, w);
        chk("full_stall_cycles", w, CMD_TICKS - 2);
        wait_idle(8*(CMD_TICKS+1), n);
        chk("b2b_strokes", strokes_done - base, 6);
        chk("b2b_sb_empty", sb.size(), 0);

        // cen at quarter rate
        cen_div = 4; base = strokes_done;
        push(cvec[2], 20, w);
        push(cvec[3], 20, w);
        wait_idle(4*2*(CMD_TICKS+1) + 40, n);
        chk("cen4_strokes", strokes_done - base, 2);
        cen_div = 1;
        tick();

        // Reset during the address wait of the second of three commands
        base = strokes_done;
        for (int i = 3; i < 6; i++) push(cvec[i], 10, w);
        n = 0;
        while (!(strokes_done == base + 1 && last_addr == 0 && prev_cls == 2) && n < 400) begin
            tick(); n++;
        end
        chk("reached_cmd2_await", n < 400 ? 1 : 0, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_levels("midrst");
        repeat (300) tick();
        chk("no_strokes_after_rst", strokes_done - base, 1);
        chk("idle_after_rst", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
